// File: rtl/dram_sched_pkg.sv
// dram_sched_pkg: state encoding, default widths and read-latency limits for dram_access_sched
package dram_sched_pkg;
  typedef enum logic [1:0] {S_HOST, S_HPEND, S_RUN, S_DONE} state_t;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  function automatic int clamp_lat(input int lat);
    return lat < RD_LAT_MIN ? RD_LAT_MIN : lat > RD_LAT_MAX ? RD_LAT_MAX : lat;
  endfunction
endpackage

// File: rtl/dram_sched_wdog.sv
// dram_sched_wdog: counts processor run cycles and flags expiry on the WDOG_CYCLES-th one
module dram_sched_wdog
  import dram_sched_pkg::*;
#(
  parameter int WDOG_CYCLES = 65535
) (
  input  logic   clk,
  input  logic   rst,
  input  state_t state,
  output logic   expire
);
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic run;
  // counter restarts from zero whenever the processor is not running
  always_comb begin
    run = state == S_RUN;
    cnt_d = run ? cnt_q + CW'(1) : '0;
    expire = run && cnt_q == CW'(WDOG_CYCLES - 1);
  end
  // run-cycle counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/dram_access_sched.sv
// dram_access_sched: shares the data RAM between host port and processor; watchdog enabled by DRAM_SCHED_WATCHDOG_EN
module dram_access_sched
  import dram_sched_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RD_LAT      = 1,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              proc_enable,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic [DATA_W-1:0] proc_rdata,
  input  logic              proc_finish,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int LAT = clamp_lat(RD_LAT);
  state_t state_q, state_d;
  logic start_lat_q, start_lat_d, hwe_q, hwe_d, timeout_q, timeout_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d, hrdata_q, hrdata_d;
  logic [LAT:0] rd_pipe_q, rd_pipe_d;
  logic run, accept, rd_ack, ack, wdog_expire;

`ifdef DRAM_SCHED_WATCHDOG_EN
  dram_sched_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk(clk),
    .rst(rst),
    .state(state_q),
    .expire(wdog_expire)
  );
`else
  assign wdog_expire = WDOG_CYCLES < 0;
`endif

  // host transaction acceptance and completion qualifiers
  always_comb begin
    run = state_q == S_RUN;
    accept = state_q == S_HOST && host_req;
    rd_ack = rd_pipe_q[LAT];
    ack = hwe_q || rd_ack;
  end

  // next state: host traffic wins over start, run ends on finish or watchdog
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOST:  state_d = host_req ? S_HPEND : (start || start_lat_q) ? S_RUN : S_HOST;
      S_HPEND: state_d = ack ? S_HOST : S_HPEND;
      S_RUN:   state_d = (proc_finish || wdog_expire) ? S_DONE : S_RUN;
      default: state_d = S_HOST;
    endcase
  end

  // host request capture, deferred start, read-latency line and sticky timeout
  always_comb begin
    start_lat_d = (accept || state_q == S_HPEND) && (start_lat_q || start);
    haddr_d = accept ? host_addr : haddr_q;
    hwdata_d = accept ? host_wdata : hwdata_q;
    hwe_d = accept && host_we;
    rd_pipe_d = {rd_pipe_q[LAT-1:0], accept && !host_we};
    hrdata_d = rd_ack ? mem_rdata : hrdata_q;
    timeout_d = (state_d == S_RUN && !run) ? 1'b0 : (run && wdog_expire && !proc_finish) ? 1'b1 : timeout_q;
  end

  // outputs: processor pass-through while running, registered host strobes otherwise
  always_comb begin
    busy = run || state_q == S_DONE;
    done = state_q == S_DONE;
    timeout = timeout_q;
    proc_enable = run;
    host_ack = ack;
    host_rdata = rd_ack ? mem_rdata : hrdata_q;
    proc_rdata = run ? mem_rdata : '0;
    mem_addr = run ? proc_addr : haddr_q;
    mem_wdata = run ? proc_wdata : hwdata_q;
    mem_we = run ? proc_write : hwe_q;
    mem_re = run ? proc_read && !proc_write : rd_pipe_q[0];
  end

  // state register
  always_ff @(posedge clk) state_q <= rst ? S_HOST : state_d;

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      start_lat_q <= 1'b0;
      haddr_q <= '0;
      hwdata_q <= '0;
      hwe_q <= 1'b0;
      rd_pipe_q <= '0;
      hrdata_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      start_lat_q <= start_lat_d;
      haddr_q <= haddr_d;
      hwdata_q <= hwdata_d;
      hwe_q <= hwe_d;
      rd_pipe_q <= rd_pipe_d;
      hrdata_q <= hrdata_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: tb/tb_dram_access_sched.sv
// tb_dram_access_sched: directed plus randomized checks of dram_access_sched against a RAM model and reference memory
module tb_dram_access_sched;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LAT = 1;
  localparam int WD = 100;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic host_req = 1'b0, host_we = 1'b0, proc_read = 1'b0, proc_write = 1'b0, proc_finish = 1'b0;
  logic [AW-1:0] host_addr = '0, proc_addr = '0, mem_addr;
  logic [DW-1:0] host_wdata = '0, proc_wdata = '0, host_rdata, proc_rdata, mem_wdata, mem_rdata;
  logic busy, done, timeout, host_ack, proc_enable, mem_we, mem_re;
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] rpipe [LAT];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [AW-1:0] addrs [$];
  int checks = 0, passes = 0, fails = 0;
  int n;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  always #5 clk = ~clk;
  dram_access_sched #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .timeout(timeout),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .proc_enable(proc_enable),
    .proc_addr(proc_addr), .proc_read(proc_read), .proc_write(proc_write),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_finish(proc_finish),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rpipe[0] <= mem_re ? ram[mem_addr] : 8'hEE;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[LAT-1];
  task automatic pass();
    checks++;
    passes++;
  endtask
  task automatic fail(input string tag);
    checks++;
    fails++;
    $error("FAIL %s", tag);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic host_xact(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] dd);
    int k;
    k = 0;
    cyc();
    host_req = 1'b1; host_we = we; host_addr = ad; host_wdata = dd;
    do begin
      cyc();
      k++;
      if (k == 1) begin
        if ({mem_we, mem_re, mem_addr} !== {we, ~we, ad}) fail("hx_mem_ctl"); else pass();
        if (we) begin
          if (mem_wdata !== dd) fail("hx_mem_wdata"); else pass();
        end
      end
    end while (!host_ack && k < 40);
    host_req = 1'b0;
    if (k !== (we ? 1 : 1 + LAT)) fail("hx_latency"); else pass();
    if (we) ref_mem[ad] = dd;
    else if (host_rdata !== ref_mem[ad]) fail("hx_rdata");
    else pass();
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) cyc();
    if ({busy, done, timeout, host_ack, proc_enable, mem_we, mem_re} !== 7'd0) fail("rst_ctl"); else pass();
    if ({host_rdata, proc_rdata, mem_wdata, mem_addr} !== 40'd0) fail("rst_data"); else pass();
    rst = 1'b0;
    cyc();
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
    cyc();
    if ({mem_re, mem_addr} !== {1'b1, 16'h0010}) fail("mr_mem_re"); else pass();
    rst = 1'b1; host_req = 1'b0;
    cyc();
    if ({busy, done, timeout, host_ack, proc_enable, mem_we, mem_re} !== 7'd0) fail("mr_ctl"); else pass();
    if ({host_rdata, proc_rdata, mem_wdata, mem_addr} !== 40'd0) fail("mr_data"); else pass();
    rst = 1'b0;
    repeat (3) begin
      cyc();
      if (host_ack !== 1'b0) fail("mr_no_ack"); else pass();
    end
    host_xact(1'b1, 16'h0100, 8'hA5);
    host_xact(1'b0, 16'h0100, 8'h00);
    addrs.push_back(16'h0100);
    for (int i = 0; i < 12; i++) begin
      if (addrs.size() < 2 || $urandom_range(1) == 1) begin
        a = 16'h0400 + 16'($urandom_range(31));
        host_xact(1'b1, a, 8'($urandom));
        addrs.push_back(a);
      end else host_xact(1'b0, addrs[$urandom_range(addrs.size() - 1)], 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      a = 16'h0500 + 16'(i);
      host_xact(1'b1, a, 8'($urandom));
      addrs.push_back(a);
    end
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    if ({proc_enable, busy, done} !== 3'b110) fail("run_enter"); else pass();
    proc_write = 1'b1; proc_read = 1'b1; proc_addr = 16'h0200; proc_wdata = 8'h3C;
    #1;
    if ({mem_we, mem_re, mem_addr, mem_wdata} !== {1'b1, 1'b0, 16'h0200, 8'h3C}) fail("run_pwrite"); else pass();
    ref_mem[16'h0200] = 8'h3C;
    addrs.push_back(16'h0200);
    for (int i = 0; i < 10; i++) begin
      cyc();
      proc_write = 1'b0; proc_read = 1'b0;
      if ($urandom_range(1) == 1) begin
        a = 16'h0600 + 16'($urandom_range(15));
        d = 8'($urandom);
        proc_write = 1'b1; proc_read = 1'($urandom_range(1)); proc_addr = a; proc_wdata = d;
        #1;
        if ({mem_we, mem_re, mem_addr, mem_wdata} !== {1'b1, 1'b0, a, d}) fail("run_rnd_wr"); else pass();
        ref_mem[a] = d;
        addrs.push_back(a);
      end else begin
        a = addrs[$urandom_range(addrs.size() - 1)];
        proc_read = 1'b1; proc_addr = a;
        #1;
        if ({mem_we, mem_re, mem_addr} !== {1'b0, 1'b1, a}) fail("run_rnd_re"); else pass();
        cyc();
        proc_read = 1'b0;
        repeat (LAT - 1) cyc();
        #1;
        if (proc_rdata !== ref_mem[a]) fail("run_rnd_rdata"); else pass();
      end
    end
    cyc();
    proc_write = 1'b0; proc_read = 1'b0; proc_finish = 1'b1;
    cyc();
    proc_finish = 1'b0; proc_write = 1'b1; proc_read = 1'b1;
    #1;
    if ({done, busy, proc_enable, mem_we, mem_re} !== 5'b11000) fail("done_pulse"); else pass();
    if (proc_rdata !== 8'h00) fail("done_prdata"); else pass();
    cyc();
    proc_write = 1'b0; proc_read = 1'b0;
    if ({done, busy, proc_enable} !== 3'b000) fail("after_done"); else pass();
    host_xact(1'b0, 16'h0200, 8'h00);
    for (int i = 0; i < 4; i++) host_xact(1'b0, addrs[$urandom_range(addrs.size() - 1)], 8'h00);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0501;
    repeat (4) begin
      cyc();
      if ({host_ack, proc_enable} !== 2'b01) fail("ct_no_ack"); else pass();
    end
    proc_finish = 1'b1;
    cyc();
    proc_finish = 1'b0;
    if ({done, host_ack} !== 2'b10) fail("ct_done"); else pass();
    n = 0;
    do begin
      cyc();
      n++;
    end while (!host_ack && n < 20);
    host_req = 1'b0;
    if (n !== 2 + LAT) fail("ct_latency"); else pass();
    if (host_rdata !== ref_mem[16'h0501]) fail("ct_rdata"); else pass();
    cyc();
    start = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0700; host_wdata = 8'h77;
    cyc();
    start = 1'b0;
    if ({host_ack, busy, mem_we} !== 3'b101) fail("sim_ack"); else pass();
    host_req = 1'b0;
    ref_mem[16'h0700] = 8'h77;
    cyc();
    if (proc_enable !== 1'b0) fail("sim_gap"); else pass();
    cyc();
    if (proc_enable !== 1'b1) fail("sim_run"); else pass();
    proc_finish = 1'b1;
    cyc();
    proc_finish = 1'b0;
    if (done !== 1'b1) fail("sim_done"); else pass();
    host_xact(1'b0, 16'h0700, 8'h00);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
`ifdef DRAM_SCHED_WATCHDOG_EN
    n = 1;
    while (!done && n < 300) begin
      cyc();
      n++;
    end
    if (n !== WD + 1) fail("wd_expire_at"); else pass();
    if ({done, timeout} !== 2'b11) fail("wd_timeout"); else pass();
    cyc();
    if ({done, busy, timeout} !== 3'b001) fail("wd_sticky"); else pass();
    start = 1'b1;
    cyc();
    start = 1'b0;
    if ({proc_enable, timeout} !== 2'b10) fail("wd_cleared"); else pass();
    repeat (WD - 1) cyc();
    if ({proc_enable, done} !== 2'b10) fail("wd_last_run"); else pass();
    proc_finish = 1'b1;
    cyc();
    proc_finish = 1'b0;
    if ({done, timeout} !== 2'b10) fail("wd_finish_edge"); else pass();
`else
    repeat (150) cyc();
    if ({proc_enable, busy, timeout} !== 3'b110) fail("nowd_still_run"); else pass();
    proc_finish = 1'b1;
    cyc();
    proc_finish = 1'b0;
    if ({done, timeout} !== 2'b10) fail("nowd_done"); else pass();
`endif
    cyc();
    if ({busy, done, proc_enable} !== 3'b000) fail("final_idle"); else pass();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
